// File: rtl/serial_word_loader.sv
// serial_word_loader
//   Assembles a WIDTH-bit word from an LSB-first serial stream under a
//   valid/ready handshake and hands it to a downstream enabled register bank
//   through a one-cycle load enable.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   sin        in   1      serial data bit
//   sin_valid  in   1      sin carries a bit this cycle
//   sin_ready  out  1      a bit can be accepted this cycle
//   flush      in   1      abort a partially assembled word
//   D          out  WIDTH  last completed word, held between loads
//   E          out  1      one-cycle load enable for the downstream bank
//   busy       out  1      word partially assembled or being loaded
//   count      out  CW     bits accepted into the current word
//
// All outputs are either registers or decodes of the state register, so
// there is no combinational path from sin/sin_valid to any output.
module serial_word_loader #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] D,
    output logic             E,
    output logic             busy,
    output logic [CW-1:0]    count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_q, shift_nxt;
    logic [WIDTH-1:0] d_q, d_nxt;
    logic [CW-1:0]    count_q, count_nxt;
    logic             xfer;

    // Handshake and status decode purely from state.
    assign sin_ready = (state != LOAD);
    assign busy      = (state != IDLE);
    assign E         = (state == LOAD);
    assign D         = d_q;
    assign count     = count_q;

    assign xfer = sin_valid && sin_ready;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            d_q     <= '0;
            count_q <= '0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            d_q     <= d_nxt;
            count_q <= count_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        d_nxt     = d_q;
        count_nxt = count_q;

        case (state)
            IDLE: begin
                // flush in IDLE swallows any simultaneous bit.
                if (xfer && !flush) begin
                    shift_nxt    = '0;
                    shift_nxt[0] = sin;
                    count_nxt    = ONE;
                    state_nxt    = SHIFT;
                end
            end

            SHIFT: begin
                if (flush) begin
                    // flush beats a simultaneous transfer.
                    shift_nxt = '0;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else if (xfer) begin
                    // One-hot write of the incoming bit at position count;
                    // avoids a variable index wider than the register.
                    for (int i = 0; i < WIDTH; i++) begin
                        if (count_q == CW'(i)) shift_nxt[i] = sin;
                    end
                    if (count_q == LAST) begin
                        d_nxt     = shift_nxt;
                        shift_nxt = '0;
                        count_nxt = '0;
                        state_nxt = LOAD;
                    end else begin
                        count_nxt = count_q + ONE;
                    end
                end
            end

            LOAD: begin
                // Input and flush are ignored; the load always completes.
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                shift_nxt = '0;
                count_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_loader.sv
module tb_serial_word_loader;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             sin = 1'b0;
    logic             sin_valid = 1'b0;
    logic             sin_ready;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] D;
    logic             E;
    logic             busy;
    logic [CW-1:0]    count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_e   = 0;   // E pulses observed since last clear
    int cyc   = 0;
    int e_cyc_a, e_cyc_b;

    always #10 clk = ~clk;

    serial_word_loader #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
        .sin_ready(sin_ready), .flush(flush), .D(D), .E(E),
        .busy(busy), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (E) n_e++;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
    endtask

    initial begin
        // 1: reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_D", 32'(D), 32'h00);
        chk("rst_E", 32'(E), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(sin_ready), 1);

        // 2: continuous 0xA5 (bits 1,0,1,0,0,1,0,1)
        n_e = 0;
        send_bit(1); send_bit(0); send_bit(1);
        chk("t2_count3", 32'(count), 3);
        chk("t2_busy", 32'(busy), 1);
        send_bit(0); send_bit(0); send_bit(1); send_bit(0);
        chk("t2_noE_bit7", 32'(E), 0);
        send_bit(1);
        sin_valid = 1'b0;
        chk("t2_E", 32'(E), 1);
        chk("t2_D", 32'(D), 32'hA5);
        chk("t2_ready_load", 32'(sin_ready), 0);
        chk("t2_count_load", 32'(count), 0);
        tick();
        chk("t2_E_off", 32'(E), 0);
        chk("t2_D_hold", 32'(D), 32'hA5);
        chk("t2_idle_busy", 32'(busy), 0);
        chk("t2_pulses", 32'(n_e), 1);

        // Flush in IDLE drops the simultaneous bit.
        flush = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        tick();
        flush = 1'b0; sin_valid = 1'b0;
        chk("idle_flush_count", 32'(count), 0);
        chk("idle_flush_busy", 32'(busy), 0);

        // 3: 0xA5 with gaps after bits 2 and 5
        n_e = 0;
        send_bit(1); send_bit(0);
        sin_valid = 1'b0; tick(); tick();
        chk("t3_gap1_count", 32'(count), 2);
        send_bit(1); send_bit(0); send_bit(0);
        sin_valid = 1'b0; sin = 1'b1; tick();
        chk("t3_gap2_count", 32'(count), 5);
        chk("t3_gap2_noE", 32'(E), 0);
        send_bit(1); send_bit(0);
        chk("t3_noE_bit7", 32'(n_e), 0);
        send_bit(1);
        sin_valid = 1'b0;
        chk("t3_E", 32'(E), 1);
        chk("t3_D", 32'(D), 32'hA5);
        tick();

        // 4: 3 bits, flush with a simultaneous bit, then 0x3C
        n_e = 0;
        send_bit(1); send_bit(1); send_bit(1);
        flush = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_count", 32'(count), 0);
        chk("t4_flush_busy", 32'(busy), 0);
        chk("t4_flush_D", 32'(D), 32'hA5);
        send_word(8'h3C);
        sin_valid = 1'b0;
        chk("t4_E", 32'(E), 1);
        chk("t4_D", 32'(D), 32'h3C);
        tick();
        chk("t4_pulses", 32'(n_e), 1);

        // 5: back-to-back 0xFF then 0x01 with sin_valid held high
        n_e = 0;
        send_word(8'hFF);
        e_cyc_a = cyc;
        chk("t5_E1", 32'(E), 1);
        chk("t5_D1", 32'(D), 32'hFF);
        // First bit of 0x01 is presented during LOAD and must not be taken.
        send_bit(1);
        chk("t5_load_skip_count", 32'(count), 0);
        chk("t5_load_E_off", 32'(E), 0);
        send_word(8'h01);
        e_cyc_b = cyc;
        sin_valid = 1'b0;
        chk("t5_E2", 32'(E), 1);
        chk("t5_D2", 32'(D), 32'h01);
        // One bubble per word: final bits WIDTH+1 edges apart.
        chk("t5_spacing", 32'(e_cyc_b - e_cyc_a), WIDTH + 1);
        tick();
        chk("t5_pulses", 32'(n_e), 2);

        // 6: reset after 5 bits, then 0x5A
        n_e = 0;
        send_bit(1); send_bit(1); send_bit(1); send_bit(1); send_bit(1);
        sin_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_D", 32'(D), 32'h00);
        send_word(8'h5A);
        sin_valid = 1'b0;
        chk("t6_E", 32'(E), 1);
        chk("t6_D", 32'(D), 32'h5A);
        tick();
        tick();
        chk("t6_pulses", 32'(n_e), 1);
        chk("t6_D_hold", 32'(D), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
